// File: rtl/instruction_rom_loader.sv
// ---------------------------------------------------------------------------
// instruction_rom_loader
//   Instruction-side responder for the 8-bit microprocessor. Serves the byte
//   at mem[pc] combinationally and accepts a byte-stream program download:
//   a length byte followed by that many program bytes. While a download is
//   in progress the processor is held in reset. It is released after the
//   final byte, so execution restarts at pc 0.
//
// Ports
//   origclk      in   system clock, rising edge
//   reset        in   asynchronous active-low reset (memory -> FILL, FSM -> RUN)
//   load_start   in   single-cycle download request, honoured in RUN only
//   load_valid   in   load_data is valid
//   load_data    in   length byte first, then program bytes
//   load_ready   out  loader accepts a byte this cycle (LEN / DATA)
//   load_error   out  sticky: length exceeded DEPTH, cleared by next start
//   pc           in   processor program counter
//   instruction  out  mem[pc], or FILL when pc >= DEPTH
//   cpu_reset    out  active-high processor reset
// ---------------------------------------------------------------------------
module instruction_rom_loader #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] FILL  = 8'h00
) (
  input  logic       origclk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       load_error,
  input  logic [7:0] pc,
  output logic [7:0] instruction,
  output logic       cpu_reset
);

  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_LEN  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [8:0] waddr_q, waddr_d;
  logic       error_q, error_d;
  logic       cpu_reset_q;
  logic [7:0] mem_q [DEPTH];
  logic       xfer;
  logic       wr_en;

  assign load_ready = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign xfer       = load_valid && load_ready;
  // Bytes beyond DEPTH are consumed but dropped; waddr is 9 bits so it never
  // wraps back onto entry 0.
  assign wr_en      = (state_q == ST_DATA) && xfer && (waddr_q < DEPTH9);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    waddr_d     = waddr_q;
    error_d     = error_q;
    case (state_q)
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LEN;
          error_d = 1'b0;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          remaining_d = load_data;
          waddr_d     = 9'd0;
          if (load_data == 8'd0) begin
            state_d = ST_REL;
          end else begin
            state_d = ST_DATA;
            if ({1'b0, load_data} > DEPTH9) error_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          waddr_d     = waddr_q + 9'd1;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = ST_REL;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge origclk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      remaining_q <= 8'd0;
      waddr_q     <= 9'd0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      waddr_q     <= waddr_d;
      error_q     <= error_d;
      // The processor reset rises with the entry into LEN. It is held for one
      // cycle beyond RELEASE, so the processor leaves reset only after the
      // loader is back in RUN with the new program fully in place.
      cpu_reset_q <= (state_q != ST_RUN) || (state_d != ST_RUN);
    end
  end

  always_ff @(posedge origclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= FILL;
    end else if (wr_en) begin
      mem_q[waddr_q[AW-1:0]] <= load_data;
    end
  end

  assign instruction = ({1'b0, pc} < DEPTH9) ? mem_q[pc[AW-1:0]] : FILL;
  assign load_error  = error_q;
  assign cpu_reset   = cpu_reset_q;

endmodule

// File: doc/instruction_rom_loader.md
# instruction_rom_loader

Instruction-side responder for the 8-bit Microprocessor: serves the instruction byte for the processor's `pc` and lets the bench or host download a program through a byte-stream loader. While a download is in progress it holds the processor in reset, and releases it after the final byte so execution restarts at `pc` 0. It sits between the host/bench and the Microprocessor `instruction`/`pc`/`reset` pins.

## Interface
- `DEPTH`, 16, number of instruction bytes stored (1..256)
- `FILL`, 8'h00, byte returned for `pc >= DEPTH` and the reset content of every entry
- `origclk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears memory to `FILL` and the FSM to RUN
- `load_start`  in  1  single-cycle request to begin a download; honoured in RUN only
- `load_valid`  in  1  `load_data` is valid
- `load_data`  in  8  length byte first, then program bytes
- `load_ready`  out  1  loader accepts a byte this cycle
- `load_error`  out  1  sticky: length exceeded `DEPTH`; cleared by the next accepted `load_start`
- `pc`  in  8  processor program counter
- `instruction`  out  8  `mem[pc]`, or `FILL` if `pc >= DEPTH`
- `cpu_reset`  out  1  active-high reset to the processor

## Operation
- States: RUN, LEN, DATA, RELEASE.
- RUN: `load_ready`=0, `cpu_reset`=0. `load_start`=1 moves to LEN and clears `load_error`.
- LEN: `load_ready`=1. A transfer (`load_valid && load_ready`) latches `remaining <= load_data` and `waddr <= 0`. Length 0 goes to RELEASE. Otherwise the FSM goes to DATA, and `load_error` is set if the length exceeds `DEPTH`.
- DATA: `load_ready`=1. Each transfer writes `mem[waddr]` only when `waddr < DEPTH`, then increments `waddr` (9-bit, no wrap) and decrements `remaining`. A byte past `DEPTH` is accepted and discarded, never wrapped to entry 0. The transfer that brings `remaining` to 0 moves the FSM to RELEASE.
- RELEASE: one cycle, `load_ready`=0, `cpu_reset`=1, then RUN.
- `cpu_reset` = 1 in LEN, DATA, RELEASE, and while `reset` is low. It is a registered output apart from the asynchronous assertion from `reset`.
- `load_start` in any state other than RUN is ignored.
- `load_valid` in RUN or RELEASE is ignored; no write occurs.
- Fetch path is combinational from `pc` and the memory array; no fetch-side state.

## Timing
- Reset, asynchronous while `reset`=0:
  - all entries = `FILL`; state RUN
  - `load_ready`=0, `load_error`=0, `cpu_reset`=1
  - `instruction` = `FILL`
- First rising edge after `reset` deasserts: `cpu_reset`=0.
- `load_start` sampled at edge k: state LEN, `cpu_reset`=1 and `load_ready`=1 from after edge k.
- Byte write at edge k: visible on `instruction` (if `pc` selects it) immediately after edge k.
- Last data transfer at edge k: RELEASE during cycle k+1, RUN and `cpu_reset`=0 after edge k+2.
- Minimum download of N bytes is N+3 cycles: start, length, N data, release.
- `load_valid` may stay high back-to-back; one byte per cycle.
- `reset` asserted mid-download: aborts immediately. Memory returns to `FILL` and the partial program is lost.

## Test plan
- Reset: hold `reset`=0 for 5 cycles, `pc`=0..15 -> `instruction`=8'h00, `cpu_reset`=1, `load_ready`=0, `load_error`=0. Release -> `cpu_reset`=0 after one edge.
- Download: `load_start`, then length 3 and bytes 8'h71, 8'h05, 8'hC2 on consecutive cycles.
  - `mem[0..2]` holds those bytes; `pc`=1 gives 8'h05; `pc`=3 gives 8'h00.
  - `cpu_reset` high for exactly 6 cycles.
- Stalled stream: same program with `load_valid` low for 4 cycles between bytes -> same contents; `cpu_reset` extended by 4 cycles; no spurious writes.
- Overflow, `DEPTH`=16: length 18, bytes 8'h10..8'h21.
  - `mem[15]`=8'h1F; `mem[0]` stays 8'h10.
  - `load_error`=1 until the next `load_start`.
  - FSM returns to RUN after 18 data bytes.
- Zero length and ignored starts:
  - length 0 -> RELEASE the following cycle; memory unchanged.
  - `load_start` pulsed during DATA -> no effect on `remaining` or contents.
- Reset mid-download: assert `reset` after 2 of 5 data bytes -> all entries 8'h00, state RUN, `load_ready`=0 asynchronously.
- Out-of-range fetch: `pc`=8'hFF -> `FILL`.
